// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the RV32I memory-access stage: size codes, write-back selects, FSM states.
// No logic of its own.
// Imported by the stage top, its interface users and the load aligner.
package core_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  localparam logic [2:0] WB_ALU   = 3'b000;
  localparam logic [2:0] WB_MEM   = 3'b001;
  localparam logic [2:0] WB_IMM   = 3'b010;
  localparam logic [2:0] WB_PCIMM = 3'b011;
  localparam logic [2:0] WB_NPC   = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Bytes never misalign; halves need an even address; words (and the illegal
  // size code, which behaves as a word) need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = off[0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of execute-side, data-memory and write-back signals of the memory-access stage.
// Pure wiring, no latency.
// slave = the stage's view; master = the environment (execute, memory, write-back) view.
interface mem_access_stage_if #(
  parameter int DMEM_AW = 30
);
  // execute -> stage
  logic                i_valid;
  logic                o_ready;
  logic [31:0]         i_alu_result;
  logic [31:0]         i_store_data;
  logic                i_mem_rd;
  logic                i_mem_wr;
  logic [1:0]          i_mem_size;
  logic                i_mem_unsigned;
  logic                i_reg_wr_en;
  logic [4:0]          i_rd_addr;
  logic [2:0]          i_reg_wr_sel;
  logic [31:0]         i_pc_immed;
  logic [31:0]         i_immed;
  logic [31:0]         i_next_pc_addr;
  // stage <-> data memory
  logic                o_dmem_req;
  logic                o_dmem_we;
  logic [DMEM_AW-1:0]  o_dmem_addr;
  logic [31:0]         o_dmem_wdata;
  logic [3:0]          o_dmem_wmask;
  logic                i_dmem_ack;
  logic [31:0]         i_dmem_rdata;
  // stage -> write-back
  logic                o_valid;
  logic [31:0]         o_alu_result;
  logic [31:0]         o_shifted_mem_data;
  logic [31:0]         o_pc_immed;
  logic [31:0]         o_immed;
  logic [31:0]         o_next_pc_addr;
  logic [2:0]          o_reg_wr_sel;
  logic                o_reg_wr_en;
  logic [4:0]          o_rd_addr;
  logic                o_misaligned;

  modport slave (
    input  i_valid, i_alu_result, i_store_data, i_mem_rd, i_mem_wr, i_mem_size,
           i_mem_unsigned, i_reg_wr_en, i_rd_addr, i_reg_wr_sel, i_pc_immed,
           i_immed, i_next_pc_addr, i_dmem_ack, i_dmem_rdata,
    output o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wmask,
           o_valid, o_alu_result, o_shifted_mem_data, o_pc_immed, o_immed,
           o_next_pc_addr, o_reg_wr_sel, o_reg_wr_en, o_rd_addr, o_misaligned
  );

  modport master (
    output i_valid, i_alu_result, i_store_data, i_mem_rd, i_mem_wr, i_mem_size,
           i_mem_unsigned, i_reg_wr_en, i_rd_addr, i_reg_wr_sel, i_pc_immed,
           i_immed, i_next_pc_addr, i_dmem_ack, i_dmem_rdata,
    input  o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wmask,
           o_valid, o_alu_result, o_shifted_mem_data, o_pc_immed, o_immed,
           o_next_pc_addr, o_reg_wr_sel, o_reg_wr_en, o_rd_addr, o_misaligned
  );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load aligner: shifts the read word down by the byte offset, then sign/zero-extends to 32 bits.
// Purely combinational.
// No flow control; reusable on any read-return path.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] shifted;

  // Bring the addressed byte/half to bit 0, then extend per size and signedness.
  always_comb begin
    shifted = i_rdata >> {i_off, 3'b000};
    case (i_size)
      MEM_B:   o_data = {{24{~i_unsigned & shifted[7]}}, shifted[7:0]};
      MEM_H:   o_data = {{16{~i_unsigned & shifted[15]}}, shifted[15:0]};
      default: o_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: registers execute outputs, runs one data-memory access, aligns load data.
// Latency: 1 cycle for non-memory/misaligned ops; memory ops complete the cycle after ack.
// Backpressure: o_ready drops while an access is outstanding; execute holds its instruction.
module mem_access_stage
  import core_pkg::*;
#(
  parameter int DMEM_AW = 30
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_access_stage_if.slave bus
);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_q, sdata_q, pcimm_q, imm_q, npc_q, ld_q;
  logic        rd_op_q, wr_op_q, uns_q, wren_q, mis_q;
  logic [1:0]  size_q;
  logic [4:0]  rd_q;
  logic [2:0]  sel_q;

  logic        ready, accept, ack_ok, req;
  logic        in_memop, in_mis, in_go_mem;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wmask;
  logic [1:0]  off;

  // Ready drops with reset so nothing is accepted while the stage is held.
  assign ready     = (state_q == ST_IDLE) & i_rst;
  assign accept    = bus.i_valid & ready;
  assign in_memop  = bus.i_mem_rd | bus.i_mem_wr;
  assign in_mis    = in_memop & is_misaligned(bus.i_mem_size, bus.i_alu_result[1:0]);
  assign in_go_mem = in_memop & ~in_mis;
  // Acks outside WAIT belong to nothing we issued and are dropped.
  assign ack_ok    = (state_q == ST_WAIT) & bus.i_dmem_ack;
  assign req       = (state_q == ST_WAIT);
  assign off       = alu_q[1:0];

  // State and completion-pulse registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Next state: aligned memory ops park in WAIT until ack; everything else completes next cycle.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_go_mem) state_d = ST_WAIT;
          else           valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ack_ok) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the whole instruction on accept; these also drive the write-back outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      alu_q   <= '0;
      sdata_q <= '0;
      pcimm_q <= '0;
      imm_q   <= '0;
      npc_q   <= '0;
      rd_op_q <= 1'b0;
      wr_op_q <= 1'b0;
      uns_q   <= 1'b0;
      wren_q  <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= '0;
      rd_q    <= '0;
      sel_q   <= '0;
    end else if (accept) begin
      alu_q   <= bus.i_alu_result;
      sdata_q <= bus.i_store_data;
      pcimm_q <= bus.i_pc_immed;
      imm_q   <= bus.i_immed;
      npc_q   <= bus.i_next_pc_addr;
      rd_op_q <= bus.i_mem_rd;
      wr_op_q <= bus.i_mem_wr;
      uns_q   <= bus.i_mem_unsigned;
      wren_q  <= bus.i_reg_wr_en;
      mis_q   <= in_mis;
      size_q  <= bus.i_mem_size;
      rd_q    <= bus.i_rd_addr;
      sel_q   <= bus.i_reg_wr_sel;
    end
  end

  load_align u_load_align (
    .i_rdata    (bus.i_dmem_rdata),
    .i_off      (off),
    .i_size     (size_q),
    .i_unsigned (uns_q),
    .o_data     (ld_data)
  );

  // Load result is sticky: only a completed load replaces it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                 ld_q <= '0;
    else if (ack_ok && rd_op_q) ld_q <= ld_data;
  end

  // Store lanes: replicate the datum across the word and enable only the addressed bytes.
  always_comb begin
    st_wdata = sdata_q;
    st_wmask = 4'b1111;
    case (size_q)
      MEM_B: begin
        st_wdata = {4{sdata_q[7:0]}};
        st_wmask = 4'b0001 << off;
      end
      MEM_H: begin
        st_wdata = {2{sdata_q[15:0]}};
        st_wmask = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  assign bus.o_ready            = ready;
  assign bus.o_dmem_req         = req;
  assign bus.o_dmem_we          = req & wr_op_q;
  assign bus.o_dmem_addr        = req ? alu_q[DMEM_AW+1:2] : '0;
  assign bus.o_dmem_wdata       = (req & wr_op_q) ? st_wdata : '0;
  assign bus.o_dmem_wmask       = (req & wr_op_q) ? st_wmask : '0;
  assign bus.o_valid            = valid_q;
  assign bus.o_alu_result       = alu_q;
  assign bus.o_shifted_mem_data = ld_q;
  assign bus.o_pc_immed         = pcimm_q;
  assign bus.o_immed            = imm_q;
  assign bus.o_next_pc_addr     = npc_q;
  assign bus.o_reg_wr_sel       = sel_q;
  assign bus.o_reg_wr_en        = wren_q & ~mis_q;
  assign bus.o_rd_addr          = rd_q;
  assign bus.o_misaligned       = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed test-plan cases, random traffic, reset mid-WAIT.
module tb_mem_access_stage;
  import core_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp, n_bad;

  mem_access_stage_if #(.DMEM_AW(30)) bus ();

  mem_access_stage #(.DMEM_AW(30)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  typedef struct {
    logic [31:0] alu, pcimm, imm, npc, ld;
    logic [2:0]  sel;
    logic        wren;
    logic [4:0]  rd;
    logic        mis;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          dly;
    int          acc;
  } mreq_t;

  exp_t        expq[$];
  mreq_t       memq[$];
  logic [31:0] last_ld;
  int          last_ack;
  bit          rsp_en;
  bit          rsp_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == MEM_B) ? 1 : (sz == MEM_H) ? 2 : 4;
  endfunction

  // Reference load: gather the addressed bytes little-endian, then extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    int     nb  = nbytes(sz);
    int     ofs = int'(a[1:0]);
    longint v   = 0;
    longint one = 1;
    for (int i = 0; i < nb; i++)
      v += longint'((w >> (8 * (ofs + i))) & 32'hFF) << (8 * i);
    if (!uns && nb < 4 && v >= (one << (8 * nb - 1)))
      v -= (one << (8 * nb));
    return v[31:0];
  endfunction

  // Present one instruction when the stage is ready and record what must come back.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sdata, input logic rd_op,
                       input logic wr_op, input logic [1:0] sz, input logic uns,
                       input logic [4:0] rd, input logic [2:0] sel,
                       input logic [31:0] rdata, input int dly);
    int    guard = 0;
    int    nb, ofs;
    exp_t  e;
    mreq_t m;
    logic  memop, wren;
    while (bus.o_ready !== 1'b1) begin
      // Junk on the bus while not ready must never be taken.
      bus.i_valid      = 1'($urandom_range(0, 1));
      bus.i_alu_result = $urandom;
      bus.i_mem_rd     = 1'($urandom_range(0, 1));
      bus.i_mem_wr     = ~bus.i_mem_rd;
      bus.i_rd_addr    = 5'($urandom);
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        flag("ready_timeout");
        return;
      end
    end
    wren = wr_op ? 1'b0 : (rd_op ? 1'b1 : ($urandom_range(0, 3) != 0));
    bus.i_valid        = 1'b1;
    bus.i_alu_result   = alu;
    bus.i_store_data   = sdata;
    bus.i_mem_rd       = rd_op;
    bus.i_mem_wr       = wr_op;
    bus.i_mem_size     = sz;
    bus.i_mem_unsigned = uns;
    bus.i_reg_wr_en    = wren;
    bus.i_rd_addr      = rd;
    bus.i_reg_wr_sel   = sel;
    bus.i_pc_immed     = $urandom;
    bus.i_immed        = $urandom;
    bus.i_next_pc_addr = $urandom;

    nb    = nbytes(sz);
    ofs   = int'(alu[1:0]);
    memop = rd_op | wr_op;
    e.alu   = alu;
    e.pcimm = bus.i_pc_immed;
    e.imm   = bus.i_immed;
    e.npc   = bus.i_next_pc_addr;
    e.sel   = sel;
    e.rd    = rd;
    e.mis   = memop && (ofs % nb != 0);
    e.wren  = e.mis ? 1'b0 : wren;
    if (rd_op && !e.mis) last_ld = ref_load(rdata, alu, sz, uns);
    e.ld      = last_ld;
    e.exp_cyc = (memop && !e.mis) ? -1 : cyc + 1;
    expq.push_back(e);
    if (memop && !e.mis) begin
      m.addr  = alu[31:2];
      m.we    = wr_op;
      m.wdata = '0;
      m.wmask = '0;
      if (wr_op)
        for (int lane = 0; lane < 4; lane++) begin
          m.wdata[8*lane +: 8] = sdata[8*(lane % nb) +: 8];
          m.wmask[lane]        = (lane >= ofs) && (lane < ofs + nb);
        end
      m.rdata = rdata;
      m.dly   = dly;
      m.acc   = cyc;
      memq.push_back(m);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // Memory responder: checks every request cycle against the model and acks after the chosen delay.
  initial begin
    mreq_t cur;
    int    cnt;
    rsp_busy = 0;
    cnt      = 0;
    forever begin
      @(negedge clk);
      if (!rsp_en) continue;
      bus.i_dmem_ack = 1'b0;
      if (bus.o_dmem_req === 1'b1) begin
        if (!rsp_busy) begin
          if (memq.size() == 0) flag("unexpected_req");
          else begin
            cur      = memq.pop_front();
            rsp_busy = 1;
            cnt      = cur.dly;
            chk("req_cycle", cyc, cur.acc + 1);
          end
        end
        if (rsp_busy) begin
          chk("dmem_addr", 32'(bus.o_dmem_addr), 32'(cur.addr));
          chk("dmem_we", 32'(bus.o_dmem_we), 32'(cur.we));
          chk("dmem_wdata", bus.o_dmem_wdata, cur.wdata);
          chk("dmem_wmask", 32'(bus.o_dmem_wmask), 32'(cur.wmask));
          chk("ready_in_wait", 32'(bus.o_ready), 32'd0);
          if (cnt == 0) begin
            bus.i_dmem_ack   = 1'b1;
            bus.i_dmem_rdata = cur.rdata;
            rsp_busy         = 0;
            last_ack         = cyc;
          end else cnt--;
        end
      end else begin
        if (rsp_busy) begin
          flag("req_dropped");
          rsp_busy = 0;
        end
        if ($urandom_range(0, 7) == 0) begin
          bus.i_dmem_ack   = 1'b1;
          bus.i_dmem_rdata = $urandom;
        end
      end
    end
  end

  // Write-back monitor: every o_valid pulse is matched in order against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) begin
        if (expq.size() == 0) flag("spurious_valid");
        else begin
          e = expq.pop_front();
          if (e.exp_cyc >= 0) chk("valid_cycle", cyc, e.exp_cyc);
          else begin
            chk("valid_cycle", cyc, last_ack + 1);
            chk("ready_after_ack", 32'(bus.o_ready), 32'd1);
          end
          chk("alu_result", bus.o_alu_result, e.alu);
          chk("mem_data", bus.o_shifted_mem_data, e.ld);
          chk("pc_immed", bus.o_pc_immed, e.pcimm);
          chk("immed", bus.o_immed, e.imm);
          chk("next_pc", bus.o_next_pc_addr, e.npc);
          chk("wr_sel", 32'(bus.o_reg_wr_sel), 32'(e.sel));
          chk("wr_en", 32'(bus.o_reg_wr_en), 32'(e.wren));
          chk("rd_addr", 32'(bus.o_rd_addr), 32'(e.rd));
          chk("misaligned", 32'(bus.o_misaligned), 32'(e.mis));
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          kind, guard;
    n_cmp = 0; n_bad = 0; last_ld = '0; last_ack = -10; rsp_en = 0;
    rst_n = 1'b0;
    bus.i_valid = 0; bus.i_alu_result = 0; bus.i_store_data = 0; bus.i_mem_rd = 0;
    bus.i_mem_wr = 0; bus.i_mem_size = 0; bus.i_mem_unsigned = 0; bus.i_reg_wr_en = 0;
    bus.i_rd_addr = 0; bus.i_reg_wr_sel = 0; bus.i_pc_immed = 0; bus.i_immed = 0;
    bus.i_next_pc_addr = 0; bus.i_dmem_ack = 0; bus.i_dmem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_req", 32'(bus.o_dmem_req), 32'd0);
    chk("rst_alu", bus.o_alu_result, 32'd0);
    chk("rst_memdata", bus.o_shifted_mem_data, 32'd0);
    rst_n  = 1'b1;
    rsp_en = 1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.o_ready), 32'd1);

    // Directed cases from the test plan.
    issue(32'h10, $urandom, 0, 0, MEM_W, 0, 5'd5, WB_ALU, 0, 0);
    issue(32'h103, $urandom, 1, 0, MEM_B, 0, 5'd6, WB_MEM, 32'h80FF1234, 0);
    issue(32'h103, $urandom, 1, 0, MEM_B, 1, 5'd7, WB_MEM, 32'h80FF1234, 0);
    issue(32'h202, 32'hABCD1234, 0, 1, MEM_H, 0, 5'd0, WB_ALU, 0, 3);
    issue(32'h101, $urandom, 1, 0, MEM_W, 0, 5'd8, WB_MEM, $urandom, 0);
    issue(32'h1, $urandom, 0, 0, MEM_B, 0, 5'd9, WB_ALU, 0, 0);
    issue(32'h2, $urandom, 0, 0, MEM_B, 0, 5'd10, WB_IMM, 0, 0);
    issue(32'h3, $urandom, 0, 0, MEM_B, 0, 5'd11, WB_NPC, 0, 0);
    issue(32'h400, $urandom, 1, 0, MEM_W, 0, 5'd12, WB_MEM, 32'hDEADBEEF, 2);
    issue(32'h4, $urandom, 0, 0, MEM_B, 0, 5'd13, WB_PCIMM, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      d    = $urandom;
      if ($urandom_range(0, 9) < 6) a = a & ~32'(nbytes(sz) - 1);
      if ($urandom_range(0, 4) == 0) begin
        bus.i_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(a, d, kind >= 4 && kind < 7, kind >= 7, sz, 1'($urandom_range(0, 1)),
            5'($urandom), 3'($urandom_range(0, 4)), $urandom, $urandom_range(0, 4));
    end

    guard = 0;
    while ((expq.size() != 0 || memq.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_wb", expq.size(), 0);
    chk("drain_mem", memq.size(), 0);

    // Reset while a load is waiting for its ack.
    issue(32'h300, $urandom, 1, 0, MEM_W, 0, 5'd3, WB_MEM, $urandom, 1000);
    repeat (2) @(negedge clk);
    rsp_en = 0;
    bus.i_dmem_ack = 1'b0;
    chk("req_before_rst", 32'(bus.o_dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_req", 32'(bus.o_dmem_req), 32'd0);
    chk("rst_wait_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_wait_ready", 32'(bus.o_ready), 32'd0);
    expq.delete();
    memq.delete();
    rsp_busy = 0;
    last_ld  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", 32'(bus.o_ready), 32'd1);
    bus.i_dmem_ack   = 1'b1;
    bus.i_dmem_rdata = 32'h12345678;
    @(negedge clk);
    bus.i_dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_ack_valid", 32'(bus.o_valid), 32'd0);
      chk("late_ack_ready", 32'(bus.o_ready), 32'd1);
      @(negedge clk);
    end
    rsp_en = 1;
    issue(32'h500, $urandom, 1, 0, MEM_H, 1, 5'd4, WB_MEM, 32'hF00DCAFE, 1);
    issue(32'h55, $urandom, 0, 0, MEM_B, 0, 5'd2, WB_ALU, 0, 0);
    guard = 0;
    while (expq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_final", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage of the RV32I core, between execute and the combinational write-back select.
- Accepts one instruction per handshake from execute and issues loads/stores to data memory over a req/ack interface.
- Aligns and sign/zero-extends load data, and registers everything write-back consumes: ALU result, shifted memory data, immediates, next PC, select code, rd.
- Holds off execute while a memory access is outstanding.

Parameters:
- DMEM_AW, 30, word-address width on the data-memory port (byte address bits [DMEM_AW+1:2]).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  execute presents an instruction.
- o_ready  out  1  stage can accept this cycle.
- i_alu_result  in  32  ALU result; the byte address for memory ops.
- i_store_data  in  32  rs2 value for stores.
- i_mem_rd  in  1  load.
- i_mem_wr  in  1  store; never set together with i_mem_rd.
- i_mem_size  in  2  00 byte, 01 half, 10 word; 11 illegal, treated as word.
- i_mem_unsigned  in  1  zero-extend loads.
- i_reg_wr_en  in  1  rd write enable.
- i_rd_addr  in  5  destination register.
- i_reg_wr_sel  in  3  write-back select code, passed through unchanged.
- i_pc_immed, i_immed, i_next_pc_addr  in  32 each  passed through.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  write.
- o_dmem_addr  out  DMEM_AW  word address.
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_wmask  out  4  byte enables.
- i_dmem_ack  in  1  completion; for reads, data is valid in the same cycle.
- i_dmem_rdata  in  32  read word.
- o_valid  out  1  write-back outputs valid.
- o_alu_result, o_shifted_mem_data, o_pc_immed, o_immed, o_next_pc_addr  out  32 each  to write-back.
- o_reg_wr_sel  out  3  to write-back.
- o_reg_wr_en  out  1  register write enable.
- o_rd_addr  out  5  destination register.
- o_misaligned  out  1  misaligned-access flag, qualified by o_valid.

Behaviour:
- Reset (i_rst low, async): state IDLE; every output 0; o_ready resumes at 1 once out of reset.
- FSM states: IDLE, WAIT.
- o_ready = (state == IDLE).
- Accept occurs when i_valid && o_ready (cycle N). All inputs are captured into internal registers on accept.
- Non-memory op: o_valid=1 in N+1 for exactly one cycle, pass-through fields registered. State stays IDLE, so back-to-back accepts give throughput 1/cycle.
- Misalignment:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - A misaligned access issues no request. It completes like a non-memory op with o_misaligned=1 and o_reg_wr_en=0.
- Aligned memory op: enter WAIT. From N+1, o_dmem_req=1 with address/we/wdata/wmask held stable until and including the ack cycle M.
- On ack in cycle M:
  - For loads, capture the extended data.
  - In M+1: o_valid=1, state IDLE, o_ready=1.
  - Minimum memory-op latency is 2 cycles (ack at N+1 gives o_valid at N+2).
- Store path:
  - o_dmem_wdata: byte = {4{b}}, half = {2{h}}, word = data.
  - o_dmem_wmask: byte = 4'b0001<<off, half = 4'b0011<<off, word = 4'b1111, where off = addr[1:0].
  - Stores report o_reg_wr_en as captured; the decoder drives it 0 for stores.
- Load path: shift i_dmem_rdata right by 8*off, take the low 8/16/32 bits, then sign- or zero-extend per i_mem_unsigned.
- o_shifted_mem_data holds the last load value until the next completed load.
- o_dmem_we=0 for loads; wdata and wmask are don't-care for loads, drive 0.
- An i_dmem_ack seen while not in WAIT is ignored.
- o_valid is a one-cycle pulse per instruction. Data outputs keep their values between pulses.
- Reset asserted in WAIT: request dropped immediately (async), the outstanding access is abandoned, and any late ack after reset is ignored.

Decomposition:
- Shared package (core_pkg):
  - mem size codes MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10.
  - write-back select codes WB_ALU=3'b000, WB_MEM=3'b001, WB_IMM=3'b010, WB_PCIMM=3'b011, WB_NPC=3'b100.
  - FSM state encoding.
- One combinational sub-module, load_align (rdata, off, size, unsigned -> 32-bit result), reusable by a future cache path.

Test Plan:
- Non-memory op: ALU add 0x00000010, sel 000, rd=5, accepted in N -> o_valid pulse in N+1, o_alu_result=0x10, o_rd_addr=5, no o_dmem_req.
- LB signed: addr 0x103, rdata 0x80FF1234, ack in N+1 -> o_dmem_addr=0x40, o_shifted_mem_data=0xFFFFFF80 in N+2; LBU on the same data gives 0x00000080.
- SH: addr 0x202, data 0xABCD1234 -> wmask=4'b1100, wdata=0x12341234, we=1. Ack held off 3 cycles -> req and fields stable throughout, o_ready=0 throughout, o_valid one cycle after ack.
- Misaligned LW at 0x101 -> no request, o_valid in N+1 with o_misaligned=1 and o_reg_wr_en=0.
- Back-to-back: three non-memory ops on consecutive cycles -> three consecutive o_valid pulses. Then a load with ack delayed 2 cycles -> o_ready low until the cycle after ack.
- Reset mid-WAIT: assert i_rst low while the request is pending -> o_dmem_req=0 and o_valid=0 immediately. A late ack after reset release produces no o_valid.
